// File: rtl/param_counter_pkg.sv
// Shared types for the multi-mode counter: counting modes and one-shot FSM states.
package param_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/counter_prescaler.sv
// Step divider: ticks on every PRESCALE-th enabled cycle. Built only with COUNTER_PRESCALE_EN.
`ifdef COUNTER_PRESCALE_EN
module counter_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic Clock,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    logic [7:0] pcnt;

    assign tick = enable && (pcnt == 8'(PRESCALE - 1));

    always_ff @(posedge Clock) begin
        if (clear) begin
            pcnt <= '0;
        end else if (enable) begin
            pcnt <= tick ? '0 : pcnt + 8'd1;
        end
    end

endmodule
`endif

// File: rtl/param_mode_counter.sv
// Up/down counter with load, programmable up-terminal and wrap/saturate/one-shot modes,
// driving a zero-padded tri-stateable bus. COUNTER_PRESCALE_EN adds a step prescaler.
//
// state   | meaning
// ST_IDLE | one-shot armed, no stepping until CountEnable
// ST_RUN  | one-shot stepping toward terminal (Busy = 1)
// ST_DONE | one-shot reached terminal, holds until Load
module param_mode_counter
    import param_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PAD      = 16,
    parameter int PRESCALE = 4
) (
    input  logic                  Clock,
    input  logic                  CountReset,
    input  logic                  CountEnable,
    input  logic                  CountDir,
    input  logic [1:0]            Mode,
    input  logic                  Load,
    input  logic [WIDTH-1:0]      LoadValue,
    input  logic [WIDTH-1:0]      Limit,
    input  logic                  OutEnable,
    output wire  [WIDTH+PAD-1:0]  Count,
    output logic                  Terminal,
    output logic                  Busy
);

    if (PRESCALE < 1 || PRESCALE > 255) begin : g_bad_prescale
        $error("PRESCALE must be in 1..255");
    end

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] wrap_val;
    logic             at_term;
    logic             lands;
    logic             tick;
    logic             step;
    mode_e            mode;
    state_e           state;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .Clock  (Clock),
        .clear  (CountReset | Load),
        .enable (CountEnable),
        .tick   (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign mode     = mode_e'(Mode);
    assign step     = CountEnable & tick;
    assign stepped  = CountDir ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
    assign at_term  = CountDir ? (cnt >= Limit) : (cnt == '0);
    // Only consulted when not already at terminal, so this is exact arrival.
    assign lands    = CountDir ? (stepped >= Limit) : (stepped == '0);
    assign wrap_val = CountDir ? '0 : Limit;

    assign Count = OutEnable ? {{PAD{1'b0}}, cnt} : {(WIDTH+PAD){1'bz}};

    always_ff @(posedge Clock) begin
        if (CountReset) begin
            cnt      <= '0;
            state    <= ST_IDLE;
            Terminal <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            Terminal <= 1'b0;
            Busy     <= 1'b0;
            if (Load) begin
                cnt   <= LoadValue;
                state <= ST_IDLE;
            end else begin
                case (mode)
                    MODE_SAT: begin
                        state <= ST_IDLE;
                        if (step && !at_term) begin
                            cnt      <= stepped;
                            Terminal <= lands;
                        end
                    end
                    MODE_ONESHOT: begin
                        case (state)
                            ST_IDLE: begin
                                if (CountEnable) begin
                                    if (at_term) begin
                                        state <= ST_DONE;
                                    end else if (tick && lands) begin
                                        cnt      <= stepped;
                                        Terminal <= 1'b1;
                                        state    <= ST_DONE;
                                    end else begin
                                        if (tick) cnt <= stepped;
                                        state <= ST_RUN;
                                        Busy  <= 1'b1;
                                    end
                                end
                            end
                            ST_RUN: begin
                                if (step && at_term) begin
                                    state <= ST_DONE;
                                end else if (step && lands) begin
                                    cnt      <= stepped;
                                    Terminal <= 1'b1;
                                    state    <= ST_DONE;
                                end else begin
                                    if (step) cnt <= stepped;
                                    Busy <= 1'b1;
                                end
                            end
                            ST_DONE: state <= ST_DONE;
                            default: state <= ST_IDLE;
                        endcase
                    end
                    default: begin
                        state <= ST_IDLE;
                        if (step) begin
                            if (at_term) begin
                                cnt <= wrap_val;
                            end else begin
                                cnt      <= stepped;
                                Terminal <= lands;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule
